// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with memory-wait timeout and sticky error states.
// Datapath selects are decoded from the registered state; PCWrite/IRWrite also follow MemReady/Zero.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic       Fault,
  output logic [3:0] State
);

  localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;
  logic          fault_q, fault_d;
  logic          mem_state;

  always_comb begin
    state_d   = state_q;
    mem_state = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_state = 1'b1;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        mem_state = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWRITE: begin
        mem_state = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
      S_JAL:     state_d = S_ALUWB;
      S_ILLEGAL: state_d = S_ILLEGAL;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FETCH;
    endcase

    // A completing access on the timeout cycle wins over the fault.
    if (mem_state && !MemReady && (wait_q == TIMEOUT_VAL)) state_d = S_FAULT;

    if ((state_d != state_q) || MemReady || !mem_state) wait_d = '0;
    else                                               wait_d = wait_q + CW'(1);

    illegal_d = (state_d == S_ILLEGAL);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    MemReq    = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    Branch    = 1'b0;
    ResultSrc = '0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    ALUOp     = '0;
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        PCWrite = Zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase

    // Reset is applied combinationally so no write strobe escapes while it is held.
    if (rst) begin
      MemReq  = 1'b0;
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end

  assign Illegal = illegal_q;
  assign Fault   = fault_q;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction's expected state trace is derived from its opcode class
// and the planned memory latencies; per-cycle outputs come from a state-indexed table.
module tb_multicycle_controller;

  localparam int unsigned T = 15;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] Op = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       Illegal, Fault;
  logic [3:0] State;
  logic [16:0] dut_vec;

  multicycle_controller #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Illegal(Illegal), .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  // {MemReq,PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,Branch}_ResultSrc_ALUSrcA_ALUSrcB_ALUOp_{Illegal,Fault}
  assign dut_vec = {MemReq, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, Fault};

  logic [16:0] tbl [13] = '{
    17'b1000000_10_00_10_00_00,  // FETCH
    17'b0000000_00_01_01_00_00,  // DECODE
    17'b0000000_00_10_01_00_00,  // MEMADR
    17'b1010000_00_00_00_00_00,  // MEMREAD
    17'b0000010_01_00_00_00_00,  // MEMWB
    17'b1010100_00_00_00_00_00,  // MEMWRITE
    17'b0000000_00_10_00_10_00,  // EXECR
    17'b0000000_00_10_01_10_00,  // EXECI
    17'b0000010_00_00_00_00_00,  // ALUWB
    17'b0000001_00_10_00_01_00,  // BEQ
    17'b0100000_00_01_10_00_00,  // JAL
    17'b0000000_00_00_00_00_10,  // ILLEGAL
    17'b0000000_00_00_00_00_01   // FAULT
  };

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] exp_vec(input int st, input bit mr, input bit z);
    logic [16:0] v;
    v = tbl[st];
    if (st == 0) begin
      v[15] = mr;
      v[13] = mr;
    end
    if (st == 9) v[15] = z;
    return v;
  endfunction

  // Called just after a falling edge; checks the current cycle and advances one cycle.
  task automatic cyc(input int st, input bit mr);
    MemReady = mr;
    #1;
    check($sformatf("state@%0d", st), 32'(State), 32'(st));
    check($sformatf("outs@%0d", st), 32'(dut_vec), 32'(exp_vec(st, mr, Zero)));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    MemReady = 1'b1;
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_outs", 32'(dut_vec), 32'(exp_vec(0, 1'b0, 1'b0) & 17'h0FFFF));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic terminal(input int st);
    repeat (3) cyc(st, 1'($urandom));
    do_reset();
  endtask

  // Ready rises after w low cycles; more than T low cycles means the access times out.
  task automatic mem_phase(input int st, input int w, output bit faulted);
    bit mr;
    faulted = 1'b1;
    for (int i = 0; i <= int'(T); i++) begin
      mr = (i >= w);
      cyc(st, mr);
      if (mr) begin
        faulted = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input bit z, input int wf, input int wm);
    bit f;
    Op = op;
    Zero = z;
    mem_phase(0, wf, f);
    if (f) begin
      terminal(12);
      return;
    end
    cyc(1, 1'($urandom));
    if (op == LW || op == SW) begin
      cyc(2, 1'($urandom));
      mem_phase((op == LW) ? 3 : 5, wm, f);
      if (f) begin
        terminal(12);
        return;
      end
      if (op == LW) cyc(4, 1'($urandom));
    end else if (op == RT) begin
      cyc(6, 1'($urandom));
      cyc(8, 1'($urandom));
    end else if (op == IT) begin
      cyc(7, 1'($urandom));
      cyc(8, 1'($urandom));
    end else if (op == BQ) begin
      cyc(9, 1'($urandom));
    end else if (op == JL) begin
      cyc(10, 1'($urandom));
      cyc(8, 1'($urandom));
    end else begin
      terminal(11);
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom % 16);
    if (r == 12) return int'(T);
    if (r == 13) return int'(T) + 1;
    return int'($urandom % 4);
  endfunction

  initial begin
    bit f;
    logic [6:0] ops [8];
    logic [6:0] op;
    ops = '{LW, SW, RT, IT, BQ, JL, 7'b0, LW};

    @(negedge clk);
    do_reset();

    run_instr(LW, 1'b0, 0, 0);
    run_instr(SW, 1'b0, 0, 3);
    run_instr(BQ, 1'b1, 0, 0);
    run_instr(BQ, 1'b0, 0, 0);
    run_instr(JL, 1'b0, 0, 0);
    run_instr(RT, 1'b0, 1, 0);
    run_instr(IT, 1'b1, 2, 0);
    run_instr(7'b1111111, 1'b0, 0, 0);
    run_instr(LW, 1'b0, int'(T), int'(T));
    run_instr(LW, 1'b0, int'(T) + 1, 0);
    run_instr(SW, 1'b0, 0, int'(T) + 1);

    // Reset in the middle of a store wait abandons the store.
    Op = SW;
    mem_phase(0, 0, f);
    cyc(1, 1'b0);
    cyc(2, 1'b0);
    cyc(5, 1'b0);
    cyc(5, 1'b0);
    do_reset();
    run_instr(LW, 1'b0, 1, 2);

    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom % 8];
      if (op == 7'b0) op = 7'($urandom);
      run_instr(op, 1'($urandom), pick_wait(), pick_wait());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
